// File: rtl/and_prober_pkg.sv
// rtl/and_prober_pkg.sv - shared types for the AND-path stimulus/measure engine
package and_prober_pkg;

    // Default width of delay, latency and window fields
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_REPORT  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Measurement outcome, held until the next report
    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] latency;
        logic                     pass;
        logic                     timeout;
        logic                     early;
    } result_t;

endpackage

// File: rtl/prober_sync2.sv
// rtl/prober_sync2.sv - two-flop synchroniser for the asynchronous path output
module prober_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; cleared asynchronously so a reset never leaves a stale response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/and_path_prober.sv
// rtl/and_path_prober.sv - launches timed rising edges on an AND path and measures its response
module and_path_prober
    import and_prober_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] dly_a,
    input  logic [CNT_W-1:0] dly_b,
    input  logic [CNT_W-1:0] lat_min,
    input  logic [CNT_W-1:0] lat_max,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] latency,
    output logic             pass,
    output logic             timeout,
    output logic             early
);

    // Last counter value before the wait budget is exhausted, and the latency reported then
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_LAT  = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] lat_meas;
    logic [CNT_W-1:0] dly_a_q, dly_b_q, lat_min_q, lat_max_q;
    logic             cnt_last;
    logic             in_window;
    logic             out_s;
    result_t          res;

    prober_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (out_s)
    );

    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
    assign cnt_last  = (cnt == TMO_LAST);
    // Response seen now was launched one cycle earlier than cnt counts, hence +1
    assign lat_meas  = cnt + 1'b1;
    assign in_window = (lat_meas >= lat_min_q) && (lat_meas <= lat_max_q);

    assign latency = res.latency;
    assign pass    = res.pass;
    assign timeout = res.timeout;
    assign early   = res.early;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_LAUNCH;
            ST_LAUNCH: begin
                if (dut_a && dut_b) state_nxt = ST_WAIT;
                else if (out_s)     state_nxt = ST_REPORT;
            end
            ST_WAIT:    if (out_s || cnt_last) state_nxt = ST_REPORT;
            ST_REPORT:  state_nxt = ST_RELEASE;
            ST_RELEASE: if (!out_s || cnt_last) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_REPORT);
    end

    // Counter, stimulus drivers, latched configuration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            dly_a_q   <= '0;
            dly_b_q   <= '0;
            lat_min_q <= '0;
            lat_max_q <= '0;
            res       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dly_a_q     <= dly_a;
                        dly_b_q     <= dly_b;
                        lat_min_q   <= lat_min;
                        lat_max_q   <= lat_max;
                        cnt         <= '0;
                        res.pass    <= 1'b0;
                        res.timeout <= 1'b0;
                        res.early   <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    cnt <= cnt_inc;
                    if (cnt == dly_a_q) dut_a <= 1'b1;
                    if (cnt == dly_b_q) dut_b <= 1'b1;
                    if (dut_a && dut_b) begin
                        cnt <= '0;
                    end else if (out_s) begin
                        // Output rose before the path was fully driven
                        res.latency <= '0;
                        res.pass    <= 1'b0;
                        res.early   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt_inc;
                    if (out_s) begin
                        res.latency <= lat_meas;
                        res.pass    <= in_window;
                    end else if (cnt_last) begin
                        res.latency <= TMO_LAT;
                        res.pass    <= 1'b0;
                        res.timeout <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    dut_a <= 1'b0;
                    dut_b <= 1'b0;
                    cnt   <= '0;
                end
                ST_RELEASE: cnt <= cnt_inc;
                default:    cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_and_path_prober.sv
// tb/tb_and_path_prober.sv - directed vector bench for and_path_prober
module tb_and_path_prober;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dly_a, dly_b, lat_min, lat_max;
    logic       dut_a, dut_b, dut_out;
    logic       busy, done, pass, timeout, early;
    logic [7:0] latency;

    // Path model: 0 zero-delay AND, 1 AND delayed mdelay cycles, 2 tied low, 3 tied high
    int         model  = 2;
    int         mdelay = 1;
    logic [7:0] sh     = '0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int dly_a, dly_b, lat_min, lat_max;
        int model, mdelay, poke;
        int e_lat, e_pass, e_tmo, e_early;
        int e_ra, e_rb, e_rel;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    always @(posedge clk) sh <= {sh[6:0], dut_a & dut_b};

    always_comb begin
        dut_out = 1'b0;
        case (model)
            0:       dut_out = dut_a & dut_b;
            1:       dut_out = sh[mdelay-1];
            3:       dut_out = 1'b1;
            default: dut_out = 1'b0;
        endcase
    end

    and_path_prober dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dly_a   (dly_a),
        .dly_b   (dly_b),
        .lat_min (lat_min),
        .lat_max (lat_max),
        .dut_a   (dut_a),
        .dut_b   (dut_b),
        .dut_out (dut_out),
        .busy    (busy),
        .done    (done),
        .latency (latency),
        .pass    (pass),
        .timeout (timeout),
        .early   (early)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int edge_i;
        int rise_a;
        int rise_b;
        int rel;
        int idle_busy;
        bit got_done;
        model  = v.model;
        mdelay = v.mdelay;
        repeat (4) tick();
        dly_a   = 8'(v.dly_a);
        dly_b   = 8'(v.dly_b);
        lat_min = 8'(v.lat_min);
        lat_max = 8'(v.lat_max);
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", idx), int'(busy), 1);
        chk($sformatf("v%0d_flags_cleared", idx), int'({pass, timeout, early}), 0);
        edge_i   = 0;
        rise_a   = -1;
        rise_b   = -1;
        got_done = 1'b0;
        while (!got_done && edge_i < 600) begin
            start = (v.poke != 0 && edge_i == 20);
            if (start) dly_a = 8'd9;
            tick();
            start = 1'b0;
            edge_i++;
            if (dut_a && rise_a < 0) rise_a = edge_i;
            if (dut_b && rise_b < 0) rise_b = edge_i;
            if (done) got_done = 1'b1;
        end
        chk($sformatf("v%0d_done_seen", idx), int'(got_done), 1);
        chk($sformatf("v%0d_latency", idx), int'(latency), v.e_lat);
        chk($sformatf("v%0d_pass", idx), int'(pass), v.e_pass);
        chk($sformatf("v%0d_timeout", idx), int'(timeout), v.e_tmo);
        chk($sformatf("v%0d_early", idx), int'(early), v.e_early);
        chk($sformatf("v%0d_rise_a", idx), rise_a, v.e_ra);
        chk($sformatf("v%0d_rise_b", idx), rise_b, v.e_rb);
        tick();
        chk($sformatf("v%0d_done_width", idx), int'(done), 0);
        rel = 0;
        while (busy && rel < 400) begin
            rel++;
            tick();
        end
        chk($sformatf("v%0d_release_cycles", idx), rel, v.e_rel);
        if (v.poke != 0) begin
            idle_busy = 0;
            repeat (5) begin
                tick();
                if (busy) idle_busy++;
            end
            chk($sformatf("v%0d_start_ignored", idx), idle_busy, 0);
        end
    endtask

    initial begin
        int done_in_rst;
        //          dly_a dly_b min max mdl dly poke lat pass tmo early ra  rb  rel
        vecs[0] = '{0,    0,    1,  4,  0,  0,  0,   2,  1,   0,  0,    1,  1,  3};
        vecs[1] = '{3,    7,    6,  8,  1,  5,  0,   7,  1,   0,  0,    4,  8,  8};
        vecs[2] = '{3,    7,    1,  3,  1,  5,  0,   7,  0,   0,  0,    4,  8,  8};
        vecs[3] = '{1,    2,    0,  255,2,  1,  0,   255,0,   1,  0,    2,  3,  1};
        vecs[4] = '{2,    5,    1,  4,  3,  1,  0,   0,  0,   0,  1,   -1, -1,  255};
        vecs[5] = '{0,    0,    5,  2,  0,  0,  0,   2,  0,   0,  0,    1,  1,  3};
        vecs[6] = '{5,    0,    2,  2,  0,  0,  0,   2,  1,   0,  0,    6,  1,  3};
        vecs[7] = '{2,    2,    3,  3,  1,  1,  0,   3,  1,   0,  0,    3,  3,  4};
        vecs[8] = '{0,    0,    0,  255,2,  1,  1,   255,0,   1,  0,    1,  1,  1};

        rst_n   = 1'b0;
        start   = 1'b0;
        dly_a   = '0;
        dly_b   = '0;
        lat_min = '0;
        lat_max = '0;
        repeat (3) tick();
        chk("rst_dut_a", int'(dut_a), 0);
        chk("rst_dut_b", int'(dut_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_latency", int'(latency), 0);
        chk("rst_flags", int'({pass, timeout, early}), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset asserted in the middle of WAIT
        model = 2;
        repeat (4) tick();
        dly_a   = 8'd0;
        dly_b   = 8'd0;
        lat_min = 8'd0;
        lat_max = 8'd255;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("rstw_pre_dut_a", int'(dut_a & dut_b & busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_dut_a", int'(dut_a), 0);
        chk("rstw_dut_b", int'(dut_b), 0);
        chk("rstw_busy", int'(busy), 0);
        done_in_rst = 0;
        repeat (3) begin
            tick();
            if (done) done_in_rst++;
        end
        chk("rstw_no_done", done_in_rst, 0);
        chk("rstw_latency", int'(latency), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rstw_idle_after", int'(busy | done | dut_a | dut_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
